// File: rtl/nibble_add_arbiter_if.sv
// Request/result bundle for nibble_add_arbiter: two requester ports plus the result port.
// master = requesters and result consumer; slave = the arbiter itself.
interface nibble_add_arbiter_if #(
  parameter int unsigned NIBBLES = 4
) ();
  localparam int unsigned W = 4 * NIBBLES;

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_cin;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_cin;

  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_cout;
  logic         res_id;

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    output req1_valid, req1_a, req1_b, req1_cin,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_sum, res_cout, res_id
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    input  req1_valid, req1_a, req1_b, req1_cin,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_sum, res_cout, res_id
  );
endinterface

// File: rtl/nibble_add_arbiter.sv
// Round-robin shared nibble-serial adder: one 4-bit add stage stepped LSB nibble first,
// carry held between steps, result returned over a valid/ready port with the requester ID.
module nibble_add_arbiter #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nibble_add_arbiter_if.slave   bus
);
  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [W-1:0]  sum_r;
  logic [IW-1:0] idx;
  logic          carry;
  logic          last;
  logic          id_r;
  logic          cout_r;
  logic          valid_r;

  logic          grant_any;
  logic          grant;
  logic [3:0]    nib_a;
  logic [3:0]    nib_b;
  logic [3:0]    nib_s;
  logic          nib_c;

  // Grant only exists in IDLE; on a tie the requester that was not served last wins.
  always_comb begin
    grant_any = 1'b0;
    grant     = 1'b0;
    if (state == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant_any = 1'b1;
        grant     = ~last;
      end else if (bus.req0_valid) begin
        grant_any = 1'b1;
      end else if (bus.req1_valid) begin
        grant_any = 1'b1;
        grant     = 1'b1;
      end
    end
  end

  assign bus.req0_ready = grant_any && !grant;
  assign bus.req1_ready = grant_any && grant;

  always_comb begin
    nib_a = a_r[4*int'(idx) +: 4];
    nib_b = b_r[4*int'(idx) +: 4];
    {nib_c, nib_s} = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      idx     <= '0;
      carry   <= 1'b0;
      last    <= 1'b1;
      id_r    <= 1'b0;
      cout_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            a_r   <= grant ? bus.req1_a   : bus.req0_a;
            b_r   <= grant ? bus.req1_b   : bus.req0_b;
            carry <= grant ? bus.req1_cin : bus.req0_cin;
            id_r  <= grant;
            last  <= grant;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_r[4*int'(idx) +: 4] <= nib_s;
          carry <= nib_c;
          idx   <= idx + IW'(1);
          if (idx == LAST_IDX) begin
            cout_r  <= nib_c;
            valid_r <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            valid_r <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.res_valid = valid_r;
  assign bus.res_sum   = sum_r;
  assign bus.res_cout  = cout_r;
  assign bus.res_id    = id_r;

  a_ready_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.req0_ready && bus.req1_ready));

  a_result_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.res_valid && !bus.res_ready) |=>
      (bus.res_valid && $stable(bus.res_sum) && $stable(bus.res_cout) && $stable(bus.res_id)));

endmodule

// File: tb/tb_nibble_add_arbiter.sv
// Randomised bench for nibble_add_arbiter: queue-driven requesters, a cycle-level model of the
// observable handshake/latency rules, and a NIBBLES=1 instance exercised with directed ops.
module tb_nibble_add_arbiter;
  localparam int unsigned N = 4;
  localparam int unsigned W = 4 * N;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         has_exp;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } op_t;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         id;
    logic         has_exp;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  nibble_add_arbiter_if #(.NIBBLES(N)) bus ();
  nibble_add_arbiter_if #(.NIBBLES(1)) bus1 ();

  nibble_add_arbiter #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  nibble_add_arbiter #(.NIBBLES(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  op_t  q0[$];
  op_t  q1[$];
  logic served[$];
  int   handshakes = 0;

  // model state
  logic have_op = 1'b0;
  int   cyc = 0;
  logic m_last = 1'b1;
  res_t cur;
  logic acc0 = 1'b0;
  logic acc1 = 1'b0;

  // stimulus controls
  logic rand_gate = 1'b0;
  logic rand_rr = 1'b0;
  int   rr_hold = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic op_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                             input logic has, input logic [W-1:0] es, input logic ec);
    op_t o;
    o.a = a; o.b = b; o.cin = cin; o.has_exp = has; o.exp_sum = es; o.exp_cout = ec;
    return o;
  endfunction

  function automatic op_t rnd_op();
    logic [W-1:0] a;
    logic [W-1:0] b;
    a = W'($urandom);
    b = W'($urandom);
    if ($urandom_range(7) == 0) a = '1;
    if ($urandom_range(7) == 0) b = W'(1);
    return mk(a, b, 1'($urandom), 1'b0, '0, 1'b0);
  endfunction

  // Reference: the adder is invisible; only accept timing, grant rule and a+b+cin matter.
  always @(negedge clk) begin
    logic v0, v1, g0, g1, exp_valid;
    logic [W:0] t;
    op_t o;
    if (!rst_n) begin
      chk("rst_res_valid", 32'(bus.res_valid), 0);
      chk("rst_res_sum",   32'(bus.res_sum),   0);
      chk("rst_res_cout",  32'(bus.res_cout),  0);
      chk("rst_res_id",    32'(bus.res_id),    0);
      have_op = 1'b0;
      m_last  = 1'b1;
      acc0    = 1'b0;
      acc1    = 1'b0;
    end else begin
      v0 = bus.req0_valid;
      v1 = bus.req1_valid;
      exp_valid = have_op && (cyc >= int'(N));
      g0 = !have_op && v0 && (!v1 || m_last == 1'b1);
      g1 = !have_op && v1 && (!v0 || m_last == 1'b0);
      chk("req0_ready", 32'(bus.req0_ready), 32'(g0));
      chk("req1_ready", 32'(bus.req1_ready), 32'(g1));
      chk("ready_onehot", 32'(bus.req0_ready && bus.req1_ready), 0);
      chk("res_valid", 32'(bus.res_valid), 32'(exp_valid));
      if (exp_valid) begin
        chk("res_sum",  32'(bus.res_sum),  32'(cur.sum));
        chk("res_cout", 32'(bus.res_cout), 32'(cur.cout));
        chk("res_id",   32'(bus.res_id),   32'(cur.id));
        if (cur.has_exp) begin
          chk("lit_sum",  32'(bus.res_sum),  32'(cur.exp_sum));
          chk("lit_cout", 32'(bus.res_cout), 32'(cur.exp_cout));
        end
      end
      acc0 = g0;
      acc1 = g1;
      if (have_op) begin
        if (exp_valid && bus.res_ready) begin
          have_op = 1'b0;
          handshakes++;
          served.push_back(cur.id);
        end else begin
          cyc++;
        end
      end else if (g0 || g1) begin
        o = g1 ? q1[0] : q0[0];
        t = {1'b0, o.a} + {1'b0, o.b} + (W+1)'(o.cin);
        cur.sum = t[W-1:0];
        cur.cout = t[W];
        cur.id = g1;
        cur.has_exp = o.has_exp;
        cur.exp_sum = o.exp_sum;
        cur.exp_cout = o.exp_cout;
        m_last = g1;
        have_op = 1'b1;
        cyc = 0;
      end
    end
  end

  // Requester/consumer driver: presents queue heads, pops on the accept the model predicted.
  always @(posedge clk) begin
    #1;
    if (acc0) void'(q0.pop_front());
    if (acc1) void'(q1.pop_front());
    bus.req0_valid = rst_n && (q0.size() > 0) && (!rand_gate || $urandom_range(3) != 0);
    bus.req1_valid = rst_n && (q1.size() > 0) && (!rand_gate || $urandom_range(3) != 0);
    if (q0.size() > 0) begin
      bus.req0_a = q0[0].a; bus.req0_b = q0[0].b; bus.req0_cin = q0[0].cin;
    end else begin
      bus.req0_a = W'($urandom); bus.req0_b = W'($urandom); bus.req0_cin = 1'($urandom);
    end
    if (q1.size() > 0) begin
      bus.req1_a = q1[0].a; bus.req1_b = q1[0].b; bus.req1_cin = q1[0].cin;
    end else begin
      bus.req1_a = W'($urandom); bus.req1_b = W'($urandom); bus.req1_cin = 1'($urandom);
    end
    if (rr_hold > 0) begin
      bus.res_ready = 1'b0;
      if (bus.res_valid) rr_hold--;
    end else begin
      bus.res_ready = rand_rr ? ($urandom_range(2) != 0) : 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || have_op) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: timeout after %0d cycles, expected idle", name, n);
    end
  endtask

  task automatic run1(input logic k, input logic [3:0] a, input logic [3:0] b, input logic cin,
                      input logic has, input logic [3:0] es, input logic ec);
    logic [4:0] t;
    t = {1'b0, a} + {1'b0, b} + 5'(cin);
    tick();
    bus1.res_ready = 1'b1;
    if (k) begin
      bus1.req1_valid = 1'b1; bus1.req1_a = a; bus1.req1_b = b; bus1.req1_cin = cin;
    end else begin
      bus1.req0_valid = 1'b1; bus1.req0_a = a; bus1.req0_b = b; bus1.req0_cin = cin;
    end
    @(negedge clk);
    chk("n1_ready0", 32'(bus1.req0_ready), 32'(!k));
    chk("n1_ready1", 32'(bus1.req1_ready), 32'(k));
    tick();
    bus1.req0_valid = 1'b0;
    bus1.req1_valid = 1'b0;
    @(negedge clk);
    chk("n1_valid_early", 32'(bus1.res_valid), 0);
    @(negedge clk);
    chk("n1_valid", 32'(bus1.res_valid), 1);
    chk("n1_sum",   32'(bus1.res_sum),   32'(t[3:0]));
    chk("n1_cout",  32'(bus1.res_cout),  32'(t[4]));
    chk("n1_id",    32'(bus1.res_id),    32'(k));
    if (has) begin
      chk("n1_lit_sum",  32'(bus1.res_sum),  32'(es));
      chk("n1_lit_cout", 32'(bus1.res_cout), 32'(ec));
    end
    @(negedge clk);
    chk("n1_valid_drop", 32'(bus1.res_valid), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int hs0;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.res_ready = 1'b1;
    bus.req0_a = '0; bus.req0_b = '0; bus.req0_cin = 1'b0;
    bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 1'b0;
    bus1.req0_valid = 1'b0; bus1.req1_valid = 1'b0; bus1.res_ready = 1'b1;
    bus1.req0_a = '0; bus1.req0_b = '0; bus1.req0_cin = 1'b0;
    bus1.req1_a = '0; bus1.req1_b = '0; bus1.req1_cin = 1'b0;

    // Both requesters pending straight out of reset: expect 0,1,0,1.
    q0.push_back(mk(16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5555, 1'b0));
    q0.push_back(mk(16'h8000, 16'h8000, 1'b1, 1'b1, 16'h0001, 1'b1));
    q1.push_back(mk(16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1));
    q1.push_back(mk(16'h0FFF, 16'h0000, 1'b1, 1'b1, 16'h1000, 1'b0));
    repeat (3) tick();
    rst_n = 1'b1;
    wait_idle(200, "tie_seq");
    chk("order0", 32'(served.size() > 0 ? served[0] : 1'bx), 0);
    chk("order1", 32'(served.size() > 1 ? served[1] : 1'bx), 1);
    chk("order2", 32'(served.size() > 2 ? served[2] : 1'bx), 0);
    chk("order3", 32'(served.size() > 3 ? served[3] : 1'bx), 1);

    // Consumer stalls five cycles in DONE.
    hs0 = handshakes;
    rr_hold = 5;
    q0.push_back(rnd_op());
    wait_idle(200, "stall");
    chk("stall_handshakes", 32'(handshakes - hs0), 1);

    // Reset while nibble 2 would be computed; the aborted op must never surface.
    hs0 = handshakes;
    q1.push_back(mk(16'hABCD, 16'h1111, 1'b1, 1'b0, '0, 1'b0));
    for (int i = 0; i < 20 && !have_op; i++) tick();
    chk("abort_accepted", 32'(have_op), 1);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_valid", 32'(bus.res_valid), 0);
    chk("post_rst_sum",   32'(bus.res_sum),   0);
    chk("post_rst_cout",  32'(bus.res_cout),  0);
    chk("post_rst_id",    32'(bus.res_id),    0);
    chk("abort_no_result", 32'(handshakes - hs0), 0);
    base = served.size();
    q0.push_back(rnd_op());
    q1.push_back(rnd_op());
    wait_idle(200, "post_rst_tie");
    chk("post_rst_first", 32'(served.size() > base ? served[base] : 1'bx), 0);
    chk("post_rst_second", 32'(served.size() > base + 1 ? served[base+1] : 1'bx), 1);

    // Random traffic with valid gaps and consumer back-pressure.
    rand_gate = 1'b1;
    rand_rr = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (q0.size() < 2 && $urandom_range(1) == 0) q0.push_back(rnd_op());
      if (q1.size() < 2 && $urandom_range(1) == 0) q1.push_back(rnd_op());
      tick();
    end
    wait_idle(4000, "random");
    rand_gate = 1'b0;
    rand_rr = 1'b0;

    // Single-nibble instance.
    run1(1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 4'hF, 1'b1);
    run1(1'b1, 4'h7, 4'h8, 1'b0, 1'b1, 4'hF, 1'b0);
    run1(1'b0, 4'h9, 4'h6, 1'b1, 1'b1, 4'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/nibble_add_arbiter.md
# nibble_add_arbiter

Sequencing and arbitration controller for the team's 4-bit ripple-carry adder slice. It adds two NIBBLES×4-bit operands by stepping one nibble per cycle through a single internal 4-bit add stage, LSB nibble first, with the carry held in a register between steps. It shares that one adder between two requesters under round-robin arbitration. It returns each result, its carry-out and the serving requester's ID over a valid/ready result port.

## Interface
- NIBBLES, default 4: operand width in nibbles. Legal range ≥1. W = 4·NIBBLES.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset: asynchronous, active-low.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 operation accepted this cycle when high together with req0_valid.
- req0_a, req0_b  input  W  requester 0 operands.
- req0_cin  input  1  requester 0 carry-in.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0, for requester 1.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_sum  output  W  (a + b + cin) mod 2^W.
- res_cout  output  1  carry out of the MSB nibble.
- res_id  output  1  index of the requester that was served.

## Operation
- FSM states:
  - IDLE: arbitrates between the requesters.
  - RUN: steps the nibbles.
  - DONE: holds the result.
- Reset values:
  - State is IDLE. res_valid, res_sum, res_cout and res_id are 0.
  - Nibble index and carry register are 0.
  - Round-robin pointer `last` = 1, so requester 0 wins the first tie.
- IDLE:
  - Grant is combinational. If only one valid is high, that requester is granted. If both are high, the requester ≠ `last` is granted.
  - reqK_ready = (state == IDLE) && grant == K. At most one ready is high at a time. Ready may depend on the same-cycle valid.
  - On accept (valid && ready): latch a, b and id. Load the carry register from cin. Set index = 0 and `last` = K. Go to RUN.
- RUN:
  - Each cycle: {c, s} = a[4i+3:4i] + b[4i+3:4i] + carry, where i = index.
  - Write s into res_sum[4i+3:4i], set carry = c and increment the index.
  - When i = NIBBLES−1: write res_cout = c, set res_valid = 1 and go to DONE.
- DONE:
  - res_sum, res_cout and res_id are held stable while res_valid && !res_ready.
  - On res_ready, res_valid drops to 0 and the FSM goes to IDLE.
- Both readies are low in RUN and DONE. A requester holds valid and its operands stable until accepted. Operand changes after acceptance have no effect.
- Arithmetic: unsigned. Overflow wraps modulo 2^W and is reported only via res_cout. NIBBLES = 1 is a single-step add.
- Reset asserted mid-RUN or mid-DONE: immediate async return to reset values. The in-flight operation is discarded and no result is produced for it.
- Deasserting valid while not granted is legal. The arbiter then serves the other requester or stays idle.

## Timing
- Accept at edge T. Nibble i is computed at edge T+1+i.
- res_valid rises after edge T+NIBBLES, i.e. NIBBLES cycles after acceptance.
- Result handshake at edge T+NIBBLES+1 at the earliest, then IDLE.
- The next accept is at edge T+NIBBLES+2 at the earliest. Peak throughput is one operation per NIBBLES+2 cycles.
- No combinational path from req* to res*. res_ready only affects the DONE→IDLE transition.

## Test plan
- NIBBLES=4; req0: a=0x1234, b=0x4321, cin=0. Required: res_sum=0x5555, res_cout=0, res_id=0. res_valid rises exactly 4 cycles after the accept edge.
- req1: a=0xFFFF, b=0x0001, cin=0. Required: sum 0x0000, cout 1, id 1. Then a=0x0FFF, b=0x0000, cin=1. Required: sum 0x1000, cout 0 (carry ripples across all nibbles).
- Both valids held high from reset with distinct operands. Required: served in the order 0, 1, 0, 1, and res_id alternates. Only one ready is ever high.
- Hold res_ready low for 5 cycles in DONE. Required: res_sum, res_cout and res_id are unchanged, both readies stay 0, and exactly one result handshake occurs.
- Assert rst_n=0 at RUN nibble 2, then release with no valids. Required: res_valid=0 and outputs 0. No stale result ever appears. The next tie grants requester 0.
- NIBBLES=1; a=0xF, b=0xF, cin=1. Required: sum 0xF, cout 1, latency 1 cycle.
